// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature decoder.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default accepted range: -55.0 C .. +125.0 C in 1/16 C units
  localparam logic [15:0] MIN_RAW_DEFAULT = 16'hFC90;
  localparam logic [15:0] MAX_RAW_DEFAULT = 16'h07D0;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned BCD_DIGS = 3;
  localparam int unsigned INT_W    = 8;

endpackage

// File: rtl/bcd_add3_step.sv
// One shift-add-3 (double dabble) iteration on a 3-digit BCD accumulator
// and an 8-bit binary shift register.
module bcd_add3_step
  import temp_pkg::*;
(
  input  logic [BCD_DIGS*BCD_W-1:0] bcd_in,
  input  logic [INT_W-1:0]          sr_in,
  output logic [BCD_DIGS*BCD_W-1:0] bcd_out,
  output logic [INT_W-1:0]          sr_out
);

  logic [BCD_DIGS*BCD_W-1:0] bcd_adj;

  // Correct each digit >= 5 by adding 3, then shift the whole chain left
  always_comb begin
    bcd_adj = bcd_in;
    for (int unsigned d = 0; d < BCD_DIGS; d++) begin
      if (bcd_in[d*BCD_W +: BCD_W] >= 4'd5)
        bcd_adj[d*BCD_W +: BCD_W] = bcd_in[d*BCD_W +: BCD_W] + 4'd3;
    end
    {bcd_out, sr_out} = {bcd_adj[BCD_DIGS*BCD_W-2:0], sr_in, 1'b0};
  end

endmodule

// File: rtl/temp_decoder.sv
// Converts a 1-wire temperature scratchpad word into sign, three BCD
// integer digits and one tenths digit, with a range-error flag.
// Fixed latency of 9 clocks from the accepting edge to out_valid.
module temp_decoder
  import temp_pkg::*;
#(
  parameter logic [15:0] MIN_RAW = MIN_RAW_DEFAULT,
  parameter logic [15:0] MAX_RAW = MAX_RAW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raw,
  input  logic        raw_valid,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_sign,
  output logic [3:0]  out_hund,
  output logic [3:0]  out_tens,
  output logic [3:0]  out_ones,
  output logic [3:0]  out_tenth,
  output logic        out_err,
  output logic        busy,
  output logic        overrun
);

  state_t state, state_next;

  logic [15:0]               raw_q;
  logic                      sign_q;
  logic                      err_q;
  logic [3:0]                tenth_q;
  logic [INT_W-1:0]          sr_q;
  logic [BCD_DIGS*BCD_W-1:0] bcd_q;
  logic [2:0]                iter_q;

  logic                      accept;
  logic                      drop;
  logic                      last_iter;

  logic [15:0]               abs_c;
  logic                      err_c;
  logic [INT_W-1:0]          int_c;
  logic [7:0]                frac10_c;
  logic [3:0]                tenth_c;

  logic [BCD_DIGS*BCD_W-1:0] bcd_n;
  logic [INT_W-1:0]          sr_n;

  assign accept    = raw_valid && ((state == IDLE) || (state == DONE && out_ready));
  assign drop      = raw_valid && ((state == CALC) || (state == CONV) ||
                                   (state == DONE && !out_ready));
  assign last_iter = (state == CONV) && (iter_q == 3'd7);

  // Magnitude, range check and fractional digit of the latched reading
  always_comb begin
    abs_c    = raw_q[15] ? (~raw_q + 16'd1) : raw_q;
    err_c    = ($signed(raw_q) < $signed(MIN_RAW)) || ($signed(raw_q) > $signed(MAX_RAW));
    int_c    = abs_c[11:4];
    frac10_c = {1'b0, abs_c[3:0], 3'b000} + {3'b000, abs_c[3:0], 1'b0};
    tenth_c  = frac10_c[7:4];
  end

  bcd_add3_step u_step (
    .bcd_in  (bcd_q),
    .sr_in   (sr_q),
    .bcd_out (bcd_n),
    .sr_out  (sr_n)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (raw_valid) state_next = CALC;
      CALC:    state_next = CONV;
      CONV:    if (iter_q == 3'd7) state_next = DONE;
      DONE:    if (out_ready) state_next = raw_valid ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Conversion datapath: latch, prepare, then iterate the BCD step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      tenth_q <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      if (accept) raw_q <= raw;
      if (state == CALC) begin
        // Out-of-range readings convert a zero value so the digits come out 0
        err_q   <= err_c;
        sr_q    <= err_c ? '0 : int_c;
        tenth_q <= err_c ? '0 : tenth_c;
        sign_q  <= !err_c && raw_q[15] && ((int_c != '0) || (tenth_c != '0));
        bcd_q   <= '0;
        iter_q  <= '0;
      end else if (state == CONV) begin
        bcd_q  <= bcd_n;
        sr_q   <= sr_n;
        iter_q <= iter_q + 3'd1;
      end
    end
  end

  // Result fields load only on the edge that enters DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sign  <= 1'b0;
      out_err   <= 1'b0;
      out_hund  <= '0;
      out_tens  <= '0;
      out_ones  <= '0;
      out_tenth <= '0;
    end else if (last_iter) begin
      out_sign  <= sign_q;
      out_err   <= err_q;
      out_hund  <= bcd_n[11:8];
      out_tens  <= bcd_n[7:4];
      out_ones  <= bcd_n[3:0];
      out_tenth <= tenth_q;
    end
  end

  // One-cycle pulse for each dropped raw_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= drop;
  end

endmodule

// File: tb/tb_temp_decoder.sv
// Self-checking bench for temp_decoder with an arithmetic reference model.
module tb_temp_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] raw = '0;
  logic        raw_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_sign, out_err, busy, overrun;
  logic [3:0]  out_hund, out_tens, out_ones, out_tenth;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  temp_decoder #(.MIN_RAW(16'hFC90), .MAX_RAW(16'h07D0)) dut (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw),
    .raw_valid (raw_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sign  (out_sign),
    .out_hund  (out_hund),
    .out_tens  (out_tens),
    .out_ones  (out_ones),
    .out_tenth (out_tenth),
    .out_err   (out_err),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Packed observation: {err, sign, hund, tens, ones, tenth}
  function automatic logic [17:0] obs();
    return {out_err, out_sign, out_hund, out_tens, out_ones, out_tenth};
  endfunction

  // Reference: decimal value from the signed reading in sixteenths of a degree
  function automatic logic [17:0] model(input logic [15:0] r);
    int v, a, ip, tn;
    logic s;
    v = int'($signed(r));
    if (v < -880 || v > 2000) return {1'b1, 17'b0};
    a  = (v < 0) ? -v : v;
    ip = a / 16;
    tn = ((a % 16) * 10) / 16;
    s  = (v < 0) && (ip != 0 || tn != 0);
    return {1'b0, s, 4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10), 4'(tn)};
  endfunction

  // Present one sample and count edges until out_valid (bounded)
  task automatic send(input logic [15:0] r, output int lat);
    @(negedge clk);
    raw = r;
    raw_valid = 1'b1;
    @(posedge clk);
    #1 raw_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({obs(), out_valid, busy, overrun} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {obs(), out_valid, busy, overrun});
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] vec [5];
    int lat;
    vec = '{16'h0191, 16'hFF5E, 16'h07D0, 16'h0800, 16'hFC90};
    foreach (vec[i]) begin
      send(vec[i], lat);
      total++;
      if (lat !== 9) begin
        bad++;
        $display("FAIL latency raw=%h got=%0d want=9", vec[i], lat);
      end
      total++;
      if (obs() !== model(vec[i])) begin
        bad++;
        $display("FAIL directed raw=%h got=%h want=%h", vec[i], obs(), model(vec[i]));
      end
      consume();
    end
    // Spot-check against literal expectations too
    send(16'h0550, lat);
    total++;
    if (obs() !== {1'b0, 1'b0, 4'd0, 4'd8, 4'd5, 4'd0}) begin
      bad++;
      $display("FAIL poweron_85 got=%h want=%h", obs(), {1'b0, 1'b0, 4'd0, 4'd8, 4'd5, 4'd0});
    end
    consume();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_consume busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_hold();
    int lat, pulses, unstable;
    logic [17:0] cap;
    send(16'h0191, lat);
    cap = obs();
    pulses = 0;
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        raw = 16'h0123;
        raw_valid = 1'b1;
      end
      @(posedge clk);
      #1 raw_valid = 1'b0;
      if (overrun) pulses++;
      if (obs() !== cap || !out_valid) unstable++;
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL hold_overrun got=%0d want=1", pulses);
    end
    total++;
    if (unstable !== 0 || cap !== model(16'h0191)) begin
      bad++;
      $display("FAIL hold_stable unstable=%0d got=%h want=%h", unstable, cap, model(16'h0191));
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    raw = 16'h0191;
    raw_valid = 1'b1;
    @(posedge clk);
    #1 raw_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({obs(), out_valid, busy, overrun} !== 21'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h want=0", {obs(), out_valid, busy, overrun});
    end
    @(negedge clk) reset = 1'b0;
    send(16'h0008, lat);
    total++;
    if (lat !== 9 || obs() !== {1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5}) begin
      bad++;
      $display("FAIL after_reset lat=%0d got=%h want=%h", lat, obs(), {1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5});
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, ovr;
    send(16'h0191, lat);
    @(negedge clk);
    out_ready = 1'b1;
    raw_valid = 1'b1;
    raw = 16'hFFF8;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    raw_valid = 1'b0;
    ovr = overrun ? 1 : 0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1 lat++;
      if (overrun) ovr++;
    end
    total++;
    if (ovr !== 0) begin
      bad++;
      $display("FAIL b2b_overrun got=%0d want=0", ovr);
    end
    total++;
    if (lat !== 9 || obs() !== model(16'hFFF8)) begin
      bad++;
      $display("FAIL b2b_result lat=%0d got=%h want=%h", lat, obs(), model(16'hFFF8));
    end
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] r;
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 3) r = 16'($urandom);
      else r = 16'(int'($urandom_range(0, 2880)) - 880);
      send(r, lat);
      total++;
      if (lat !== 9 || obs() !== model(r)) begin
        bad++;
        $display("FAIL random raw=%h lat=%0d got=%h want=%h", r, lat, obs(), model(r));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
